// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers (optional Cancel via MULDIV_CANCEL_EN).
// Latency: Busy rises the cycle after acceptance and stays high WIDTH+1 cycles; HI/LO update on the FINISH edge.
// Backpressure: Busy asks the hazard unit to stall; Start is ignored while Busy=1.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       MdCode,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef MULDIV_CANCEL_EN
  input  logic             Cancel,
`endif
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  // FSM and iteration state
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Operation context captured at acceptance
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;          // negate product / quotient
  logic               rem_neg_q, rem_neg_d;  // remainder takes dividend sign
  logic               dz_q, dz_d;            // divide by zero
  logic [WIDTH-1:0]   opnd_q, opnd_d;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   dvd_q, dvd_d;          // original dividend, returned on divide by zero
  // Shared accumulator: {partial product, multiplier} or {remainder, quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Architectural registers and completion pulses
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, divzero_q, divzero_d;

  logic               cancel_w;
`ifdef MULDIV_CANCEL_EN
  assign cancel_w = Cancel;
`else
  assign cancel_w = 1'b0;
`endif

  // Operand decode and magnitudes for the accepting edge
  logic               op_mul, op_div, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // Classify the incoming opcode and form operand magnitudes
  always_comb begin
    op_mul    = (MdCode == OP_MULT) || (MdCode == OP_MULTU);
    op_div    = (MdCode == OP_DIV)  || (MdCode == OP_DIVU);
    op_signed = (MdCode == OP_MULT) || (MdCode == OP_DIV);
    a_neg     = op_signed & A[WIDTH-1];
    b_neg     = op_signed & B[WIDTH-1];
    a_mag     = a_neg ? (~A + 1'b1) : A;
    b_mag     = b_neg ? (~B + 1'b1) : B;
  end

  // One iteration step of shift-add multiply and restoring divide
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [2*WIDTH-1:0] div_next;

  // Compute the next accumulator value for both datapaths
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    // A borrow means the divisor did not fit: keep the shifted remainder, quotient bit 0.
    if (div_trial[WIDTH]) begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  // Sign-corrected results presented on the FINISH edge
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Apply sign correction to the raw magnitude results
  always_comb begin
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic for the IDLE/RUN/FINISH controller and HI/LO
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    opnd_d    = opnd_q;
    dvd_d     = dvd_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (op_mul || op_div) begin
            state_d   = S_RUN;
            cnt_d     = '0;
            is_div_d  = op_div;
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            dz_d      = op_div && (B == '0);
            dvd_d     = A;
            // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
            opnd_d    = op_mul ? a_mag : b_mag;
            acc_d     = {{WIDTH{1'b0}}, (op_mul ? b_mag : a_mag)};
          end else if (MdCode == OP_MTHI) begin
            hi_d = A;
          end else if (MdCode == OP_MTLO) begin
            lo_d = A;
          end
        end
      end

      S_RUN: begin
        if (cancel_w) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          if (cnt_q == LAST_ITER) begin
            state_d = S_FINISH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
        if (!cancel_w) begin
          done_d    = 1'b1;
          divzero_d = dz_q;
          if (dz_q) begin
            hi_d = dvd_q;
            lo_d = '1;
          end else if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset that overrides any start or completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      opnd_q    <= '0;
      dvd_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      opnd_q    <= opnd_d;
      dvd_q     <= dvd_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign Busy    = (state_q != S_IDLE);
  assign Done    = done_q;
  assign DivZero = divzero_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, beside the single-cycle combinational ALU.
- Accepts the same two 32-bit operands (forwarded rs/rt values) plus a mult/div opcode from the decoder.
- Computes over multiple cycles and holds results in the architectural HI/LO registers.
- Returns a Busy stall request to the hazard unit, which holds IF/ID and bubbles EX while a result is pending or a HI/LO access collides.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each, and iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the rising edge where it is 1
- MdCode  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
- Start  input  1  qualifies MdCode this cycle (EX-stage instruction valid and not flushed)
- A  input  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo source)
- B  input  WIDTH  rt operand (divisor / multiplier)
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register
- Busy  output  1  operation in flight; pipeline must stall mfhi/mflo and new MdCode ops
- Done  output  1  one-cycle pulse on the cycle HI/LO first show a new mult/div result
- DivZero  output  1  one-cycle pulse coincident with Done when the completed op was div/divu with B==0

Behaviour:
- Reset: HI=0, LO=0, Busy=0, Done=0, DivZero=0, FSM=IDLE, iteration counter=0. Reset wins over any concurrent Start or completion; an in-flight op is discarded without Done.
- FSM states: IDLE, RUN, FINISH.
- IDLE -> RUN on an edge with Start=1 and MdCode in {001..100}.
  - Operands latched. Signed ops record signs and use magnitudes.
  - Busy=1 from the next cycle.
- RUN:
  - One iteration per cycle, WIDTH cycles (counter 0..WIDTH-1).
  - Multiply: shift-add.
  - Divide: restoring, one quotient bit per cycle.
- RUN -> FINISH after the last iteration. FINISH applies sign correction and writes HI/LO, then returns to IDLE. Busy drops on that same edge, and Done/DivZero are high for the following cycle.
- Latency: acceptance edge E0; Busy is high for WIDTH+1 cycles; HI/LO are updated at edge E0+WIDTH+1.
- mthi/mtlo:
  - In IDLE, with Start=1, write A to HI/LO at the edge; single cycle, no Busy, no Done.
  - Ignored while Busy=1 (the hazard unit must stall them).
- Start with any op while Busy=1: ignored, with no state change. MdCode 000/111 never changes state.
- Arithmetic:
  - mult: signed 2*WIDTH product, HI=upper half, LO=lower half.
  - multu: unsigned product, same split.
  - div: LO=quotient truncated toward zero; HI=remainder with the dividend's sign.
  - divu: unsigned quotient/remainder.
  - div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0; no flag, no trap.
- Divide by zero (B==0) on div/divu:
  - Completes with normal latency.
  - LO=all ones, HI=A (the original dividend, unmodified).
  - DivZero pulses with Done.
- HI/LO hold their value between operations and during RUN; the old value stays visible until the FINISH edge.

Optional Feature:
- Macro MULDIV_CANCEL_EN.
- Defined: adds input port Cancel (1 bit), used on exception/flush.
  - Cancel=1 on an edge while Busy=1 returns the FSM to IDLE.
  - HI/LO are unchanged, Done/DivZero stay 0, and Busy=0 from the next cycle.
  - Cancel in IDLE has no effect.
  - Cancel and Start on the same IDLE edge: Cancel is ignored and Start is accepted.
- Not defined: no Cancel port; only reset aborts an operation.

Test Plan:
- Reset, then mult with A=7, B=0xFFFFFFFD -> Busy high for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, one-cycle Done.
- multu with A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 at E0+33.
- div with A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu with A=100, B=0 -> LO=0xFFFFFFFF, HI=100, DivZero and Done both high for exactly one cycle.
- mthi with A=0x12345678 in IDLE -> HI=0x12345678 next cycle, Busy stays 0. mtlo (A=0xDEADBEEF) and a second mult issued mid-RUN are both ignored: LO and the final result come from the first op only.
- reset asserted at cycle 10 of a multu -> next cycle HI=LO=0, Busy=0, no Done. With MULDIV_CANCEL_EN, Cancel at cycle 5 of a div -> HI/LO keep their prior values, Busy=0, no Done.
